// File: rtl/vga_timing_gen.sv
// Pixel-clock raster timing generator with four bring-up test patterns.
// All outputs are registered from the previous cycle's counters (latency 1).
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk_1x,
  input  logic        sys_rst,
  input  logic        en,
  input  logic [1:0]  pat_sel,
  output logic [7:0]  rgb_red,
  output logic [7:0]  rgb_green,
  output logic [7:0]  rgb_blue,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [10:0] pix_x,
  output logic [10:0] pix_y,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] h_cnt;
  logic [10:0] v_cnt;
  logic [1:0]  pat_reg;
  logic [1:0]  pat_cur;
  logic        active;
  logic        h_sync_on;
  logic        v_sync_on;
  logic        frame_first;
  logic [7:1]  bar_ge;
  logic [2:0]  bar_idx;
  logic [7:0]  red_next;
  logic [7:0]  green_next;
  logic [7:0]  blue_next;

  // One comparator per bar boundary replaces a divide by BAR_W.
  for (genvar gi = 1; gi < 8; gi++) begin : g_bar
    assign bar_ge[gi] = (h_cnt >= 11'(gi * BAR_W));
  end

  always_comb begin
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (bar_ge[i]) bar_idx = 3'(i);
    end
  end

  always_comb begin
    active      = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    h_sync_on   = (h_cnt >= HS_START) && (h_cnt < HS_END);
    v_sync_on   = (v_cnt >= VS_START) && (v_cnt < VS_END);
    frame_first = (h_cnt == 11'd0) && (v_cnt == 11'd0);
    // The new selection must already drive pixel (0,0) of the frame it is latched for.
    pat_cur     = frame_first ? pat_sel : pat_reg;
  end

  always_comb begin
    red_next   = 8'h00;
    green_next = 8'h00;
    blue_next  = 8'h00;
    if (active) begin
      unique case (pat_cur)
        2'd0: begin
          // Bar colour bits map directly onto the bar index: R=~b1, G=~b2, B=~b0.
          red_next   = {8{~bar_idx[1]}};
          green_next = {8{~bar_idx[2]}};
          blue_next  = {8{~bar_idx[0]}};
        end
        2'd1: red_next = 8'hF8;
        2'd2: begin
          red_next   = h_cnt[7:0];
          green_next = h_cnt[7:0];
          blue_next  = h_cnt[7:0];
        end
        default: begin
          red_next   = {8{~(h_cnt[5] ^ v_cnt[5])}};
          green_next = {8{~(h_cnt[5] ^ v_cnt[5])}};
          blue_next  = {8{~(h_cnt[5] ^ v_cnt[5])}};
        end
      endcase
    end
  end

  always_ff @(posedge clk_1x or posedge sys_rst) begin
    if (sys_rst) begin
      h_cnt   <= 11'd0;
      v_cnt   <= 11'd0;
      pat_reg <= 2'd0;
    end else if (!en) begin
      h_cnt <= 11'd0;
      v_cnt <= 11'd0;
    end else begin
      if (frame_first) pat_reg <= pat_sel;
      if (h_cnt == H_LAST) begin
        h_cnt <= 11'd0;
        v_cnt <= (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
      end else begin
        h_cnt <= h_cnt + 11'd1;
      end
    end
  end

  always_ff @(posedge clk_1x or posedge sys_rst) begin
    if (sys_rst) begin
      de          <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      pix_x       <= 11'd0;
      pix_y       <= 11'd0;
      frame_start <= 1'b0;
      rgb_red     <= 8'h00;
      rgb_green   <= 8'h00;
      rgb_blue    <= 8'h00;
    end else if (!en) begin
      de          <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      pix_x       <= 11'd0;
      pix_y       <= 11'd0;
      frame_start <= 1'b0;
      rgb_red     <= 8'h00;
      rgb_green   <= 8'h00;
      rgb_blue    <= 8'h00;
    end else begin
      de          <= active;
      hsync       <= h_sync_on ? SYNC_POL : ~SYNC_POL;
      vsync       <= v_sync_on ? SYNC_POL : ~SYNC_POL;
      pix_x       <= active ? h_cnt : 11'd0;
      pix_y       <= active ? v_cnt : 11'd0;
      frame_start <= frame_first;
      rgb_red     <= red_next;
      rgb_green   <= green_next;
      rgb_blue    <= blue_next;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a reduced raster so whole frames fit a short run.
// Expectations are queued when stimulus is applied and popped when the DUT output is sampled.
module tb_vga_timing_gen;

  localparam int HA = 64, HF = 8, HS = 16, HB = 8;
  localparam int VA = 40, VF = 3, VS = 2, VB = 5;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int BW = HA / 8;

  logic        clk_1x = 1'b0;
  logic        sys_rst;
  logic        en;
  logic [1:0]  pat_sel;
  logic [7:0]  rgb_red, rgb_green, rgb_blue;
  logic        hsync, vsync, de, frame_start;
  logic [10:0] pix_x, pix_y;
  logic [23:0] rgb;

  assign rgb = {rgb_red, rgb_green, rgb_blue};

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .clk_1x(clk_1x), .sys_rst(sys_rst), .en(en), .pat_sel(pat_sel),
    .rgb_red(rgb_red), .rgb_green(rgb_green), .rgb_blue(rgb_blue),
    .hsync(hsync), .vsync(vsync), .de(de),
    .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start)
  );

  always #5 clk_1x = ~clk_1x;

  string       tag_q[$];
  logic [31:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic push(input string tag, input logic [31:0] exp);
    tag_q.push_back(tag);
    exp_q.push_back(exp);
  endtask

  task automatic chk(input logic [31:0] obs);
    string       tag;
    logic [31:0] exp;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty: observed %0h required nothing queued", obs);
      return;
    end
    tag = tag_q.pop_front();
    exp = exp_q.pop_front();
    $display("[tb] %s observed=%0h expected=%0h", tag, obs, exp);
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_1x);
    #1;
  endtask

  int de_total, de_line0, hs_line0, hs_first, vs_cnt, vs_first, fs_cnt;
  int de_first_low;
  logic [23:0] cap0, cap1, cap2, cap3, cap4;
  logic [10:0] capx;
  logic found, idle_bad;

  initial begin
    sys_rst = 1'b1;
    en      = 1'b0;
    pat_sel = 2'd0;
    step(3);

    // Reset state
    push("rst_de", 0); push("rst_hsync", 1); push("rst_vsync", 1);
    push("rst_fs", 0); push("rst_rgb", 0); push("rst_pix", 0);
    chk(de); chk(hsync); chk(vsync); chk(frame_start); chk(rgb); chk({pix_x, pix_y});

    sys_rst = 1'b0;
    step(2);
    push("idle_en_low_de", 0); push("idle_en_low_hsync", 1);
    chk(de); chk(hsync);

    // En rising: pixel (0,0) with frame_start one cycle later; then a full frame of statistics.
    en = 1'b1;
    push("first_fs", 1); push("first_pix", 0); push("first_de", 1);
    push("line0_de_count", HA); push("line0_hsync_count", HS); push("hsync_first_idx", HA + HF);
    push("frame_de_count", HA * VA); push("vsync_count", VS * HT); push("vsync_first_idx", (VA + VF) * HT);
    push("fs_per_frame", 1);
    push("bar_px0", 24'hFFFFFF); push("bar_px_bw", 24'hFFFF00); push("bar_px_7bw_m1", 24'h0000FF);
    push("bar_px_last", 24'h000000); push("rgb_after_active", 24'h000000); push("pix_x_after_active", 0);
    push("frame_period_fs", 1);
    step(1);
    chk(frame_start); chk({pix_x, pix_y}); chk(de);

    // Mid-frame change must not affect this frame's bars.
    pat_sel = 2'd1;
    de_total = 0; de_line0 = 0; hs_line0 = 0; hs_first = -1;
    vs_cnt = 0; vs_first = -1; fs_cnt = 0;
    cap0 = 'x; cap1 = 'x; cap2 = 'x; cap3 = 'x; cap4 = 'x; capx = 'x;
    for (int idx = 0; idx < FRAME; idx++) begin
      if (de) de_total++;
      if (idx < HT && de) de_line0++;
      if (idx < HT && !hsync) hs_line0++;
      if (!hsync && hs_first < 0) hs_first = idx;
      if (!vsync) vs_cnt++;
      if (!vsync && vs_first < 0) vs_first = idx;
      if (frame_start) fs_cnt++;
      if (idx == 0)          cap0 = rgb;
      if (idx == BW)         cap1 = rgb;
      if (idx == 7 * BW - 1) cap2 = rgb;
      if (idx == HA - 1)     cap3 = rgb;
      if (idx == HA) begin cap4 = rgb; capx = pix_x; end
      step(1);
    end
    chk(de_line0); chk(hs_line0); chk(hs_first);
    chk(de_total); chk(vs_cnt); chk(vs_first); chk(fs_cnt);
    chk(cap0); chk(cap1); chk(cap2); chk(cap3); chk(cap4); chk(capx);
    chk(frame_start);

    // Frame B is solid; a mid-frame switch to checker waits for the next frame.
    push("solid_frame_start", 24'hF80000);
    chk(rgb);
    step(5 * HT + 3);
    push("solid_mid", 24'hF80000);
    chk(rgb);
    pat_sel = 2'd3;
    step(1);
    push("solid_after_sel_change", 24'hF80000);
    chk(rgb);

    push("next_frame_found", 1); push("checker_00", 24'hFFFFFF); push("checker_00_pix", 0);
    found = 1'b0;
    for (int i = 0; i < FRAME + 10; i++) begin
      step(1);
      if (frame_start) begin found = 1'b1; break; end
    end
    chk(found); chk(rgb); chk({pix_x, pix_y});
    step(32);
    push("checker_32_0", 24'h000000); push("checker_32_0_pix", {11'd32, 11'd0});
    chk(rgb); chk({pix_x, pix_y});
    step(32 * HT);
    push("checker_32_32", 24'hFFFFFF); push("checker_32_32_pix", {11'd32, 11'd32});
    chk(rgb); chk({pix_x, pix_y});

    // Asynchronous reset mid-line while hsync is asserted.
    step(HA + HF + 1 - 32);
    push("hsync_before_rst", 0);
    chk(hsync);
    sys_rst = 1'b1;
    #2;
    push("async_rst_hsync", 1); push("async_rst_de", 0); push("async_rst_rgb", 0);
    chk(hsync); chk(de); chk(rgb);
    step(2);
    sys_rst = 1'b0;
    push("post_rst_fs", 1); push("post_rst_pix", 0); push("post_rst_de", 1);
    step(1);
    chk(frame_start); chk({pix_x, pix_y}); chk(de);

    // En dropped mid-line inside hsync, held low 10 cycles, then raised.
    step(HA + HF + 2);
    push("hsync_before_en_drop", 0);
    chk(hsync);
    en = 1'b0;
    idle_bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (de || !hsync || !vsync || frame_start || rgb != 24'h0) idle_bad = 1'b1;
    end
    push("idle_while_en_low", 0);
    chk(idle_bad);
    en = 1'b1;
    push("restart_fs", 1); push("restart_pix", 0);
    push("restart_line_de_count", HA); push("restart_de_first_low", HA);
    step(1);
    chk(frame_start); chk({pix_x, pix_y});
    de_line0 = 0; de_first_low = -1;
    for (int idx = 0; idx < HT; idx++) begin
      if (de) de_line0++;
      if (!de && de_first_low < 0) de_first_low = idx;
      step(1);
    end
    chk(de_line0); chk(de_first_low);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_leftover: observed %0d pending required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
